note_to_cnt: RTL and testbench

Converts a MIDI note number into the half-period count a square-wave tone generator needs. The output is the number of `clk_i` cycles per half-period of the note's equal-tempered frequency (A4 = 440 Hz) at a fixed 1 MHz system clock. It sits between the note/sequencer logic and the tone counter, which toggles its output every `halfCntPeriod_o` cycles.

---
 rtl/note_to_cnt_pkg.sv | 38 +++
 rtl/note_to_cnt_split.sv | 32 +++
 rtl/note_to_cnt.sv | 68 ++++++
 tb/tb_note_to_cnt.sv | 119 +++++++++++
 4 files changed

// File: rtl/note_to_cnt_pkg.sv
// Shared constants for the MIDI note to half-period count converter.
package note2cnt_pkg;

  // Nominal system clock. Every BASE entry below assumes this frequency.
  localparam int unsigned CLK_HZ        = 1_000_000;
  localparam int unsigned NOTES_PER_OCT = 12;
  localparam int unsigned MAX_OCT       = 10;

  // Half-period counts for octave -1 (notes 0..11), round(1e6 / (2*f)).
  localparam logic [15:0] BASE [12] = '{
    16'd61156, 16'd57723, 16'd54484, 16'd51426,
    16'd48540, 16'd45815, 16'd43244, 16'd40817,
    16'd38526, 16'd36364, 16'd34323, 16'd32396
  };

  // Table lookup. Semitone codes 12..15 cannot come out of the note splitter;
  // they map to 0, which reads downstream as silence.
  function automatic logic [15:0] base_lookup(input logic [3:0] semi);
    logic [15:0] val;
    case (semi)
      4'd0:    val = BASE[0];
      4'd1:    val = BASE[1];
      4'd2:    val = BASE[2];
      4'd3:    val = BASE[3];
      4'd4:    val = BASE[4];
      4'd5:    val = BASE[5];
      4'd6:    val = BASE[6];
      4'd7:    val = BASE[7];
      4'd8:    val = BASE[8];
      4'd9:    val = BASE[9];
      4'd10:   val = BASE[10];
      4'd11:   val = BASE[11];
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/note_to_cnt_split.sv
// Splits a 7-bit note number into octave (note / 12) and semitone (note % 12)
// with a fixed chain of compare/subtract steps instead of a divider.
module note_split
  import note2cnt_pkg::*;
(
  input  logic [6:0] note_i,
  output logic [3:0] oct_o,
  output logic [3:0] semi_o
);

  logic [6:0] rem_s;
  logic [3:0] oct_s;

  // Ten conditional subtractions of 12 are enough for 127 (= 10*12 + 7).
  always_comb begin
    rem_s = note_i;
    oct_s = 4'd0;
    for (int i = 0; i < int'(MAX_OCT); i++) begin
      if (rem_s >= 7'(NOTES_PER_OCT)) begin
        rem_s = rem_s - 7'(NOTES_PER_OCT);
        oct_s = oct_s + 4'd1;
      end else begin
        rem_s = rem_s;
        oct_s = oct_s;
      end
    end
  end

  assign oct_o  = oct_s;
  assign semi_o = rem_s[3:0];

endmodule

// File: rtl/note_to_cnt.sv
// MIDI note number to tone-generator half-period count (clk_i cycles) at 1 MHz.
// Path: split -> BASE lookup -> rounding right shift -> rest mux -> register.
module note_to_cnt
  import note2cnt_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic          clk_i,
  input  logic          nrst_i,   // synchronous, active-high
  input  logic [7:0]    note_i,
  output logic [BW-1:0] halfCntPeriod_o
);

  logic [3:0]    oct_s;
  logic [3:0]    semi_s;
  logic [15:0]   base_s;
  logic [16:0]   sum_s;
  logic [16:0]   shifted_s;
  logic [15:0]   cnt_s;
  logic [BW-1:0] cnt_d;
  logic [BW-1:0] cnt_q;

  note_split u_split (
    .note_i (note_i[6:0]),
    .oct_o  (oct_s),
    .semi_o (semi_s)
  );

  assign base_s = base_lookup(semi_s);

  // Round-to-nearest octave shift; the 17-bit sum keeps the carry of the
  // rounding half-LSB when the base is close to 65535.
  always_comb begin
    sum_s     = {1'b0, base_s};
    shifted_s = sum_s;
    if (oct_s != 4'd0) begin
      sum_s     = {1'b0, base_s} + (17'd1 << (oct_s - 4'd1));
      shifted_s = sum_s >> oct_s;
    end else begin
      sum_s     = {1'b0, base_s};
      shifted_s = sum_s;
    end
  end

  // Bit 7 marks a rest: force silence, otherwise pass the shifted count.
  always_comb begin
    cnt_s = 16'd0;
    if (note_i[7]) begin
      cnt_s = 16'd0;
    end else begin
      cnt_s = shifted_s[15:0];
    end
  end

  assign cnt_d = BW'(cnt_s);

  // Output register; reset wins over any note.
  always_ff @(posedge clk_i) begin
    if (nrst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign halfCntPeriod_o = cnt_q;

endmodule

// File: tb/tb_note_to_cnt.sv
// Self-checking bench for note_to_cnt: directed reference notes, reset, rest,
// back-to-back latency sweep, real-valued accuracy sweep and random notes.
module tb_note_to_cnt;

  localparam int BW = 20;

  logic          clk = 1'b0;
  logic          nrst;
  logic [7:0]    note;
  logic [BW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  note_to_cnt #(.BW(BW)) dut (
    .clk_i           (clk),
    .nrst_i          (nrst),
    .note_i          (note),
    .halfCntPeriod_o (cnt)
  );

  always #5 clk = ~clk;

  // Octave -1 half periods, straight from the frequency table.
  int base_tab [12] = '{61156, 57723, 54484, 51426, 48540, 45815,
                        43244, 40817, 38526, 36364, 34323, 32396};

  // Integer golden model: divide, then round to nearest by adding half a step.
  function automatic int model(input int n);
    int o, s, d;
    if (n >= 128) return 0;
    o = n / 12;
    s = n % 12;
    if (o == 0) return base_tab[s];
    d = 1 << o;
    return (base_tab[s] + d / 2) / d;
  endfunction

  // Ideal equal-tempered half period, rounded.
  function automatic int ideal(input int n);
    real f;
    f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return $rtoi(1.0e6 / (2.0 * f) + 0.5);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic [7:0] n);
    @(negedge clk);
    nrst = r;
    note = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    int diff;
    int r;
    nrst = 1'b1;
    note = 8'd69;

    // Reset held with a valid note: output stays 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd69);
      check("reset_hold", int'(cnt), 0);
    end
    step(1'b0, 8'd69);
    check("reset_release_a4", int'(cnt), 1136);

    // Reference notes.
    step(1'b0, 8'd60);  check("c4", int'(cnt), 1911);
    step(1'b0, 8'd0);   check("note0", int'(cnt), 61156);
    step(1'b0, 8'd11);  check("note11", int'(cnt), 32396);
    step(1'b0, 8'd127); check("g9", int'(cnt), 40);
    step(1'b0, 8'd12);  check("note12", int'(cnt), 30578);

    // Rests, then back to a note.
    step(1'b0, 8'd128); check("rest128", int'(cnt), 0);
    step(1'b0, 8'd255); check("rest255", int'(cnt), 0);
    step(1'b0, 8'd72);  check("c5_after_rest", int'(cnt), 956);

    // Reset overrides a note mid-stream, then first valid output one edge later.
    step(1'b1, 8'd40);  check("reset_mid", int'(cnt), 0);
    step(1'b0, 8'd40);  check("release_mid", int'(cnt), model(40));

    // New note every cycle: model, ideal accuracy and monotonicity.
    prev = 1 << 30;
    for (int n = 0; n < 128; n++) begin
      step(1'b0, 8'(n));
      check("sweep_model", int'(cnt), model(n));
      diff = int'(cnt) - ideal(n);
      if (diff < 0) diff = -diff;
      check("sweep_err_le1", int'(diff <= 1), 1);
      check("sweep_monotonic", int'(int'(cnt) <= prev), 1);
      check("sweep_nonzero", int'(cnt != 0), 1);
      prev = int'(cnt);
    end

    // Random notes (including rests) with occasional reset pulses.
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 19) == 0) ? 1 : 0;
      note = 8'($urandom_range(0, 255));
      step(r[0], note);
      check("random", int'(cnt), (r == 1) ? 0 : model(int'(note)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
